// File: rtl/intr_ctrl_pkg.sv
// intr_ctrl_pkg
//   Shared definitions for the interrupt controller.
//   - Byte offsets of the register map.
//   - The helper that sizes the source-ID field.
//   ID 0 means "no source", so NSRC sources need room for NSRC+1 codes.
package intr_ctrl_pkg;

  localparam int unsigned IP_OFFSET        = 32'h000;
  localparam int unsigned IE_OFFSET        = 32'h004;
  localparam int unsigned LE_OFFSET        = 32'h008;
  localparam int unsigned THRESHOLD_OFFSET = 32'h00C;
  localparam int unsigned CLAIM_OFFSET     = 32'h010;
  localparam int unsigned PRIO_BASE        = 32'h100;

  // Width of an ID field able to hold 0 (none) through nsrc.
  function automatic int unsigned idw(input int unsigned nsrc);
    return $clog2(nsrc + 1);
  endfunction

endpackage

// File: rtl/intr_gateway.sv
// intr_gateway
//   Per-source gateway. It turns one interrupt line into a pending/in-service
//   pair and handles level- and edge-triggered sources.
//
// Ports
//   clk_i, rst_ni  clock, asynchronous active-low reset
//   src_i          raw interrupt line, synchronous to clk_i
//   le_i           1 = edge-triggered, 0 = level-triggered
//   claim_i        this source is being claimed this cycle
//   complete_i     a complete for this source's ID is written this cycle
//   pending_o      source is waiting to be claimed
//   in_service_o   source has been claimed and not yet completed
module intr_gateway (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic src_i,
  input  logic le_i,
  input  logic claim_i,
  input  logic complete_i,
  output logic pending_o,
  output logic in_service_o
);

  logic src_q, src_d;
  logic pending_q, pending_d;
  logic in_service_q, in_service_d;
  logic edge_held_q, edge_held_d;

  logic rise;
  logic complete_ok;
  logic busy;
  logic set_req;

  // Gateway next-state logic.
  // A complete is applied before any new event, so an edge arriving in the
  // complete cycle sees the source as free. A claim overrides a set in the
  // same cycle. An edge that loses to a claim, or that arrives while the
  // source is in service, is parked in the single-entry edge_held store.
  always_comb begin
    rise        = src_i & ~src_q;
    complete_ok = complete_i & in_service_q;
    busy        = in_service_q & ~complete_ok;
    set_req     = le_i ? rise : src_i;

    src_d        = src_i;
    pending_d    = pending_q;
    in_service_d = in_service_q;
    edge_held_d  = edge_held_q;

    if (complete_ok) begin
      in_service_d = 1'b0;
      if (edge_held_q) begin
        pending_d   = 1'b1;
        edge_held_d = 1'b0;
      end
    end

    if (claim_i) begin
      pending_d    = 1'b0;
      in_service_d = 1'b1;
      if (le_i && rise) begin
        edge_held_d = 1'b1;
      end
    end else if (set_req) begin
      if (!busy) begin
        pending_d = 1'b1;
      end else if (le_i) begin
        edge_held_d = 1'b1;
      end
    end
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      src_q        <= 1'b0;
      pending_q    <= 1'b0;
      in_service_q <= 1'b0;
      edge_held_q  <= 1'b0;
    end else begin
      src_q        <= src_d;
      pending_q    <= pending_d;
      in_service_q <= in_service_d;
      edge_held_q  <= edge_held_d;
    end
  end

  assign pending_o    = pending_q;
  assign in_service_o = in_service_q;

endmodule

// File: rtl/intr_ctrl.sv
// intr_ctrl
//   Register-mapped, PLIC-style interrupt controller. It has per-source
//   gateways, priorities, a threshold and a claim/complete handshake. The
//   block drives one prioritised, registered request to the core.
//
// Ports
//   clk_i, rst_ni  clock, asynchronous active-low reset
//   intr_src_i     interrupt lines, active-high (source i has ID i+1)
//   reg_we/reg_re  register write/read strobes
//   reg_addr       byte address
//   reg_wdata      write data
//   reg_be         byte enables (writes must be full-word)
//   reg_rdata      read data, combinational while reg_re is high
//   reg_error      access error, combinational with the strobe
//   irq_o          registered request to the core
//   irq_id_o       registered ID of the best pending source
module intr_ctrl
  import intr_ctrl_pkg::*;
#(
  parameter  int unsigned AW    = 9,
  parameter  int unsigned DW    = 32,
  parameter  int unsigned NSRC  = 8,
  parameter  int unsigned PRIOW = 3,
  localparam int unsigned IDW   = idw(NSRC)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [NSRC-1:0]   intr_src_i,
  input  logic              reg_we,
  input  logic              reg_re,
  input  logic [AW-1:0]     reg_addr,
  input  logic [DW-1:0]     reg_wdata,
  input  logic [DW/8-1:0]   reg_be,
  output logic [DW-1:0]     reg_rdata,
  output logic              reg_error,
  output logic              irq_o,
  output logic [IDW-1:0]    irq_id_o
);

  // Configuration registers.
  logic [NSRC-1:0]  ie_q, ie_d;
  logic [NSRC-1:0]  le_q, le_d;
  logic [PRIOW-1:0] thr_q, thr_d;
  logic [PRIOW-1:0] prio_q [NSRC];
  logic [PRIOW-1:0] prio_d [NSRC];

  // Output request registers.
  logic             irq_q, irq_d;
  logic [IDW-1:0]   irq_id_q, irq_id_d;

  // Gateway interface.
  logic [NSRC-1:0]  pending;
  logic [NSRC-1:0]  in_service;
  logic [NSRC-1:0]  claim_vec;
  logic [NSRC-1:0]  complete_vec;

  // Decode.
  logic             hit_ip, hit_ie, hit_le, hit_thr, hit_claim;
  logic [NSRC-1:0]  hit_prio;
  logic             mapped;
  logic [IDW-1:0]   wr_id;
  logic             bad_id;
  logic             wr_err;
  logic             rd_err;
  logic             wr_ok;

  // Arbiter.
  logic             win_valid;
  logic [IDW-1:0]   win_id;
  logic [PRIOW-1:0] win_prio;
  logic [NSRC-1:0]  win_onehot;

  // Only the low bits of the write word reach any register. Every bit is
  // folded here so that the unused ones are accounted for.
  logic unused_wdata;
  assign unused_wdata = ^reg_wdata;

  // Address decode and error classification.
  // Only exact word addresses are mapped, so unaligned byte addresses fall
  // out as unmapped. An errored write is turned into a no-op through wr_ok.
  always_comb begin
    hit_ip    = (reg_addr == AW'(IP_OFFSET));
    hit_ie    = (reg_addr == AW'(IE_OFFSET));
    hit_le    = (reg_addr == AW'(LE_OFFSET));
    hit_thr   = (reg_addr == AW'(THRESHOLD_OFFSET));
    hit_claim = (reg_addr == AW'(CLAIM_OFFSET));
    hit_prio  = '0;
    for (int unsigned i = 0; i < NSRC; i++) begin
      hit_prio[i] = (reg_addr == AW'(PRIO_BASE + 4 * i));
    end
    mapped = hit_ip | hit_ie | hit_le | hit_thr | hit_claim | (|hit_prio);

    wr_id  = reg_wdata[IDW-1:0];
    bad_id = (wr_id == '0) || (32'(wr_id) > NSRC);

    wr_err = reg_we && (!mapped || !(&reg_be) || hit_ip || (hit_claim && bad_id));
    rd_err = reg_re && !mapped;
    wr_ok  = reg_we && !wr_err;
  end

  assign reg_error = wr_err | rd_err;

  // Priority arbiter.
  // The scan runs from the lowest ID upward and only replaces the current
  // best on a strictly higher priority, so ties go to the lowest ID. The
  // running best starts at 0. Any eligible source is above the threshold,
  // so it always beats that starting value.
  always_comb begin
    win_valid  = 1'b0;
    win_id     = '0;
    win_prio   = '0;
    win_onehot = '0;
    for (int i = 0; i < int'(NSRC); i++) begin
      if (pending[i] && ie_q[i] && !in_service[i] &&
          (prio_q[i] > thr_q) && (prio_q[i] > win_prio)) begin
        win_valid     = 1'b1;
        win_id        = IDW'(i + 1);
        win_prio      = prio_q[i];
        win_onehot    = '0;
        win_onehot[i] = 1'b1;
      end
    end
  end

  // Claim and complete strobes to the gateways.
  // A claim with no winner touches nothing. A complete is routed by ID, and
  // the gateway itself ignores it if the source is not in service.
  always_comb begin
    claim_vec    = '0;
    complete_vec = '0;
    if (reg_re && hit_claim && win_valid) begin
      claim_vec = win_onehot;
    end
    for (int i = 0; i < int'(NSRC); i++) begin
      complete_vec[i] = wr_ok && hit_claim && (wr_id == IDW'(i + 1));
    end
  end

  // One gateway per interrupt source.
  for (genvar g = 0; g < int'(NSRC); g++) begin : g_src
    intr_gateway u_gateway (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .src_i        (intr_src_i[g]),
      .le_i         (le_q[g]),
      .claim_i      (claim_vec[g]),
      .complete_i   (complete_vec[g]),
      .pending_o    (pending[g]),
      .in_service_o (in_service[g])
    );
  end

  // Register file next state. Fields are truncated to their width, and
  // the remaining bits of the write word are dropped.
  always_comb begin
    ie_d  = ie_q;
    le_d  = le_q;
    thr_d = thr_q;
    for (int i = 0; i < int'(NSRC); i++) begin
      prio_d[i] = prio_q[i];
    end
    if (wr_ok) begin
      if (hit_ie) begin
        ie_d = reg_wdata[NSRC-1:0];
      end
      if (hit_le) begin
        le_d = reg_wdata[NSRC-1:0];
      end
      if (hit_thr) begin
        thr_d = reg_wdata[PRIOW-1:0];
      end
      for (int i = 0; i < int'(NSRC); i++) begin
        if (hit_prio[i]) begin
          prio_d[i] = reg_wdata[PRIOW-1:0];
        end
      end
    end
  end

  // Read mux.
  // A CLAIM read returns the live arbiter result, or 0 when there is none.
  always_comb begin
    reg_rdata = '0;
    if (reg_re) begin
      if (hit_ip) begin
        reg_rdata[NSRC-1:0] = pending;
      end
      if (hit_ie) begin
        reg_rdata[NSRC-1:0] = ie_q;
      end
      if (hit_le) begin
        reg_rdata[NSRC-1:0] = le_q;
      end
      if (hit_thr) begin
        reg_rdata[PRIOW-1:0] = thr_q;
      end
      if (hit_claim) begin
        reg_rdata[IDW-1:0] = win_id;
      end
      for (int i = 0; i < int'(NSRC); i++) begin
        if (hit_prio[i]) begin
          reg_rdata[PRIOW-1:0] = prio_q[i];
        end
      end
    end
  end

  // The request to the core is the previous cycle's arbitration result.
  always_comb begin
    irq_d    = win_valid;
    irq_id_d = win_id;
  end

  // Configuration and output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ie_q     <= '0;
      le_q     <= '0;
      thr_q    <= '0;
      for (int i = 0; i < int'(NSRC); i++) begin
        prio_q[i] <= '0;
      end
      irq_q    <= 1'b0;
      irq_id_q <= '0;
    end else begin
      ie_q     <= ie_d;
      le_q     <= le_d;
      thr_q    <= thr_d;
      for (int i = 0; i < int'(NSRC); i++) begin
        prio_q[i] <= prio_d[i];
      end
      irq_q    <= irq_d;
      irq_id_q <= irq_id_d;
    end
  end

  assign irq_o    = irq_q;
  assign irq_id_o = irq_id_q;

endmodule

// File: tb/tb_intr_ctrl.sv
// tb_intr_ctrl
//   Self-checking bench for intr_ctrl.
//   A register-level behavioural model tracks the controller state. A
//   compare process checks irq_o, irq_id_o, reg_error and reg_rdata
//   against that model on every cycle. Directed scenarios add literal
//   expectations that were worked out by hand.
module tb_intr_ctrl;

   localparam int NSRC = 8;
   localparam int IDW  = 4;
   localparam int AW   = 9;
   localparam int DW   = 32;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [NSRC-1:0] intr_src = '0;
   logic            reg_we = 1'b0;
   logic            reg_re = 1'b0;
   logic [AW-1:0]   reg_addr = '0;
   logic [DW-1:0]   reg_wdata = '0;
   logic [3:0]      reg_be = '0;
   logic [DW-1:0]   reg_rdata;
   logic            reg_error;
   logic            irq_o;
   logic [IDW-1:0]  irq_id_o;

   int checks = 0;
   int failures = 0;

   logic [DW-1:0]   last_rdata;
   logic            last_err;
   logic            last_irq;
   logic [IDW-1:0]  last_id;

   intr_ctrl dut (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .intr_src_i (intr_src),
      .reg_we     (reg_we),
      .reg_re     (reg_re),
      .reg_addr   (reg_addr),
      .reg_wdata  (reg_wdata),
      .reg_be     (reg_be),
      .reg_rdata  (reg_rdata),
      .reg_error  (reg_error),
      .irq_o      (irq_o),
      .irq_id_o   (irq_id_o)
   );

   // Free-running clock, 10 time units per cycle.
   always #5 clk = ~clk;

   // Model state: what software would believe about the controller.
   bit m_pend [NSRC];
   bit m_insv [NSRC];
   bit m_held [NSRC];
   bit m_prev [NSRC];
   bit m_ie   [NSRC];
   bit m_le   [NSRC];
   int m_prio [NSRC];
   int m_thr;
   bit m_irq;
   int m_id;

   task automatic checkOutput(input string name, input longint actual, input longint expected);
      checks++;
      if (actual != expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   function automatic void modelReset();
      for (int i = 0; i < NSRC; i++) begin
         m_pend[i] = 0; m_insv[i] = 0; m_held[i] = 0; m_prev[i] = 0;
         m_ie[i] = 0; m_le[i] = 0; m_prio[i] = 0;
      end
      m_thr = 0;
      m_irq = 0;
      m_id  = 0;
   endfunction

   // Best eligible source: highest priority first, then the lowest ID. Returns 0 if none.
   function automatic int modelWinner();
      int best = 0;
      int bestPrio = -1;
      for (int i = 0; i < NSRC; i++) begin
         if (m_pend[i] && m_ie[i] && !m_insv[i] && m_prio[i] > m_thr && m_prio[i] > bestPrio) begin
            best = i + 1;
            bestPrio = m_prio[i];
         end
      end
      return best;
   endfunction

   function automatic bit modelMapped(input int a);
      if (a == 0 || a == 4 || a == 8 || a == 12 || a == 16) return 1;
      return (a >= 256) && (a < 256 + 4 * NSRC) && (a % 4 == 0);
   endfunction

   function automatic bit modelError();
      int a = int'(reg_addr);
      int id = int'(reg_wdata) & ((1 << IDW) - 1);
      if (!reg_we && !reg_re) return 0;
      if (!modelMapped(a)) return 1;
      if (reg_we && (reg_be != 4'hF || a == 0 || (a == 16 && (id == 0 || id > NSRC)))) return 1;
      return 0;
   endfunction

   function automatic int modelRead();
      int a = int'(reg_addr);
      int v = 0;
      case (a)
         0:  for (int i = 0; i < NSRC; i++) v |= int'(m_pend[i]) << i;
         4:  for (int i = 0; i < NSRC; i++) v |= int'(m_ie[i]) << i;
         8:  for (int i = 0; i < NSRC; i++) v |= int'(m_le[i]) << i;
         12: v = m_thr;
         16: v = modelWinner();
         default: if (a >= 256) v = m_prio[(a - 256) / 4];
      endcase
      return v;
   endfunction

   // One clock edge as seen from software: claim and complete events
   // first, then what each source line did, then register writes. The
   // request output takes the arbitration result from before the edge.
   function automatic void modelStep();
      int  win = modelWinner();
      bit  err = modelError();
      int  a = int'(reg_addr);
      int  claimed = 0;
      int  completed = 0;
      int  id = int'(reg_wdata) & ((1 << IDW) - 1);
      if (reg_re && a == 16) claimed = win;
      if (reg_we && !err && a == 16 && m_insv[id - 1]) completed = id;
      for (int i = 0; i < NSRC; i++) begin
         bit src;
         bit rise;
         bit wants;
         src   = intr_src[i];
         rise  = src && !m_prev[i];
         wants = m_le[i] ? rise : src;
         if (completed == i + 1) begin
            m_insv[i] = 0;
            if (m_held[i]) begin
               m_pend[i] = 1;
               m_held[i] = 0;
            end
         end
         if (claimed == i + 1) begin
            m_pend[i] = 0;
            m_insv[i] = 1;
            if (m_le[i] && rise) m_held[i] = 1;
         end else if (wants) begin
            if (!m_insv[i]) m_pend[i] = 1;
            else if (m_le[i]) m_held[i] = 1;
         end
         m_prev[i] = src;
      end
      if (reg_we && !err) begin
         case (a)
            4:  for (int i = 0; i < NSRC; i++) m_ie[i] = reg_wdata[i];
            8:  for (int i = 0; i < NSRC; i++) m_le[i] = reg_wdata[i];
            12: m_thr = int'(reg_wdata) & 7;
            default: if (a >= 256) m_prio[(a - 256) / 4] = int'(reg_wdata) & 7;
         endcase
      end
      m_irq = (win != 0);
      m_id  = win;
   endfunction

   // The model advances on each clock edge and clears on asynchronous reset.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) modelReset();
      else modelStep();
   end

   // Compare the DUT against the model in the middle of every cycle out of reset.
   always @(negedge clk) begin
      if (rst_n) begin
         checkOutput("irq_o", longint'(irq_o), longint'(m_irq));
         checkOutput("irq_id_o", longint'(irq_id_o), longint'(m_id));
         if (reg_we || reg_re) checkOutput("reg_error", longint'(reg_error), longint'(modelError()));
         if (reg_re && !modelError()) checkOutput("reg_rdata", longint'(reg_rdata), longint'(modelRead()));
      end
   end

   // One bus cycle: drive just after a rising edge, sample at the falling edge, then return to idle.
   task automatic applyStimulus(input bit we, input bit re, input int addr, input int data, input logic [3:0] be);
      reg_we    = we;
      reg_re    = re;
      reg_addr  = AW'(addr);
      reg_wdata = DW'(data);
      reg_be    = be;
      @(negedge clk);
      last_rdata = reg_rdata;
      last_err   = reg_error;
      last_irq   = irq_o;
      last_id    = irq_id_o;
      @(posedge clk);
      #1;
      reg_we = 1'b0; reg_re = 1'b0; reg_addr = '0; reg_wdata = '0; reg_be = '0;
   endtask

   task automatic wr(input int addr, input int data);
      applyStimulus(1'b1, 1'b0, addr, data, 4'hF);
   endtask

   task automatic rd(input int addr);
      applyStimulus(1'b0, 1'b1, addr, 0, 4'h0);
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) applyStimulus(1'b0, 1'b0, 0, 0, 4'h0);
   endtask

   initial begin
      modelReset();
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_irq", longint'(irq_o), 0);
      checkOutput("reset_id", longint'(irq_id_o), 0);
      rst_n = 1'b1;
      rd(0);
      checkOutput("reset_ip", longint'(last_rdata), 0);

      // Level source 0: the request follows pending by one cycle.
      wr(4, 1); wr('h100, 1); wr(12, 0);
      intr_src[0] = 1'b1;
      idle(2);
      checkOutput("t1_irq_before", longint'(last_irq), 0);
      idle(1);
      checkOutput("t1_irq", longint'(last_irq), 1);
      checkOutput("t1_id", longint'(last_id), 1);
      rd(16);
      checkOutput("t1_claim", longint'(last_rdata), 1);
      intr_src[0] = 1'b0;
      idle(1);
      wr(16, 1);
      checkOutput("t1_complete_err", longint'(last_err), 0);
      idle(2);
      rd(0);
      checkOutput("t1_ip_clear", longint'(last_rdata), 0);

      // Equal priorities fall back to the lowest ID; a raised priority wins.
      wr(4, 'h24); wr('h108, 3); wr('h114, 3);
      intr_src[2] = 1'b1; intr_src[5] = 1'b1;
      idle(2);
      rd(16);
      checkOutput("t2_tie_claim", longint'(last_rdata), 3);
      wr(16, 3);
      wr('h114, 4);
      rd(16);
      checkOutput("t2_prio_claim", longint'(last_rdata), 6);
      intr_src[2] = 1'b0; intr_src[5] = 1'b0;
      idle(1);
      rd(16);
      checkOutput("t2_left_claim", longint'(last_rdata), 3);
      wr(16, 3); wr(16, 6); wr(4, 0);
      idle(1);
      rd(0);
      checkOutput("t2_ip_clear", longint'(last_rdata), 0);

      // Edge source 1: two edges while in service collapse into one re-request.
      wr(8, 2); wr(4, 2); wr('h104, 2);
      intr_src[1] = 1'b1; idle(1); intr_src[1] = 1'b0; idle(2);
      rd(16);
      checkOutput("t3_claim1", longint'(last_rdata), 2);
      intr_src[1] = 1'b1; idle(1); intr_src[1] = 1'b0; idle(1);
      intr_src[1] = 1'b1; idle(1); intr_src[1] = 1'b0; idle(1);
      wr(16, 2);
      rd(0);
      checkOutput("t3_ip_reassert", longint'(last_rdata), 2);
      rd(16);
      checkOutput("t3_claim2", longint'(last_rdata), 2);
      wr(16, 2);
      idle(3);
      checkOutput("t3_irq_quiet", longint'(last_irq), 0);
      rd(0);
      checkOutput("t3_ip_quiet", longint'(last_rdata), 0);
      wr(8, 0); wr(4, 0);

      // Threshold: equal to the priority blocks the request, one below lets it through.
      wr(4, 1); wr('h100, 5); wr(12, 5);
      intr_src[0] = 1'b1;
      idle(3);
      checkOutput("t4_irq_blocked", longint'(last_irq), 0);
      rd(16);
      checkOutput("t4_claim_none", longint'(last_rdata), 0);
      wr(12, 4);
      idle(2);
      checkOutput("t4_irq", longint'(last_irq), 1);
      checkOutput("t4_id", longint'(last_id), 1);
      rd(16);
      checkOutput("t4_claim", longint'(last_rdata), 1);
      intr_src[0] = 1'b0;
      idle(1);
      wr(16, 1); wr(4, 0); wr(12, 0);

      // Access errors; an errored write must leave the registers alone.
      rd('h0F0);
      checkOutput("t5_unmapped_err", longint'(last_err), 1);
      wr(0, 'hFF);
      checkOutput("t5_ip_write_err", longint'(last_err), 1);
      applyStimulus(1'b1, 1'b0, 4, 'hFF, 4'h3);
      checkOutput("t5_partial_be_err", longint'(last_err), 1);
      rd(4);
      checkOutput("t5_ie_unchanged", longint'(last_rdata), 0);
      wr(16, 0);
      checkOutput("t5_id0_err", longint'(last_err), 1);
      wr(16, NSRC + 1);
      checkOutput("t5_idmax_err", longint'(last_err), 1);
      wr(16, 4);
      checkOutput("t5_idle_complete_err", longint'(last_err), 0);

      // Reset in the middle of service.
      wr(4, 9); wr('h100, 2); wr('h10C, 1); wr(12, 0);
      intr_src[0] = 1'b1; intr_src[3] = 1'b1;
      idle(3);
      rd(16);
      checkOutput("t6_claim", longint'(last_rdata), 1);
      idle(2);
      checkOutput("t6_irq_before_reset", longint'(last_irq), 1);
      checkOutput("t6_id_before_reset", longint'(last_id), 4);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("t6_irq_in_reset", longint'(irq_o), 0);
      checkOutput("t6_id_in_reset", longint'(irq_id_o), 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      idle(2);
      rd(0);
      checkOutput("t6_ip_after_reset", longint'(last_rdata), 9);
      wr(4, 1); wr('h100, 1);
      idle(2);
      checkOutput("t6_irq_rerequest", longint'(last_irq), 1);
      checkOutput("t6_id_rerequest", longint'(last_id), 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
